mem_port_arbiter: RTL and testbench

Shares the single-ported unified instruction/data memory between the fetch stage and the datapath memory stage (memw load/store).
- Arbitrates requests and sequences a req/ack transaction to memory, one at a time.
- Returns read data with a one-cycle valid strobe to the requester.
- Drives stall outputs that the pipeline control ORs into the existing LDR-hazard stall.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/arb_wait_timer.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Purpose : Shared encodings for the unified memory port arbiter: FSM states,
//           owner identifiers and the default no-ack timeout.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_TERM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_e;

  localparam int ARB_TIMEOUT_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/arb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : arb_wait_timer
// Purpose : Wait-cycle counter for multi-cycle handshakes. Clear has priority
//           over increment. 'last' flags that the current count is one short
//           of LIMIT, so one more increment completes LIMIT waited cycles.
// Ports   : clk, reset (async, active-low)
//           clear - return count to zero
//           inc   - advance count by one
//           last  - count == LIMIT-1
// Revision: 1.0 - initial release
// ============================================================================
module arb_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Compared against the pre-increment value so the decision does not
  // depend combinationally on 'inc'.
  assign last = (count_q == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one single-ported instruction/data memory between fetch
//           and the memory stage. One registered req/ack transaction at a
//           time; data requests win at arbitration. Completion is a one-cycle
//           valid pulse to the owner; a no-ack timeout forces completion.
// Ports   : clk, reset (async, active-low)
//           if_req/if_addr -> if_rdata/if_valid          fetch port
//           d_rd_req/d_wr_req/d_addr/d_wdata -> d_rdata/d_valid  data port
//           mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ack  memory
//           stall_fetch, stall_data                      pipeline stalls
//           err_timeout, err_proto                       sticky error flags
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_fetch,
  output logic              stall_data,
  output logic              err_timeout,
  output logic              err_proto
);

  arb_state_e        state_q,       state_d;
  arb_owner_e        owner_q,       owner_d;
  logic              mem_req_q,     mem_req_d;
  logic              mem_we_q,      mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_proto_q,   err_proto_d;

  logic d_req;
  logic load_data;
  logic load_fetch;
  logic timer_clear;
  logic timer_inc;
  logic timer_last;
  logic done;

  assign d_req = d_rd_req | d_wr_req;
  assign done  = (state_q == ARB_BUSY) && mem_ack;

  arb_wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .inc   (timer_inc),
    .last  (timer_last)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q | (d_rd_req & d_wr_req);
    load_data     = 1'b0;
    load_fetch    = 1'b0;
    timer_clear   = 1'b0;
    timer_inc     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        timer_clear = 1'b1;
        if (d_req) begin
          load_data = 1'b1;
        end else if (if_req) begin
          load_fetch = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (mem_ack) begin
          timer_clear = 1'b1;
          // The completing owner still holds its request this cycle, so
          // only the other requester may take the port back-to-back.
          if ((owner_q == OWNER_FETCH) && d_req) begin
            load_data = 1'b1;
          end else if ((owner_q == OWNER_DATA) && if_req) begin
            load_fetch = 1'b1;
          end else begin
            state_d   = ARB_IDLE;
            mem_req_d = 1'b0;
          end
        end else begin
          timer_inc = 1'b1;
          if (timer_last) begin
            state_d   = ARB_TERM;
            mem_req_d = 1'b0;
          end
        end
      end
      ARB_TERM: begin
        timer_clear   = 1'b1;
        err_timeout_d = 1'b1;
        state_d       = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A simultaneous read+write request is executed as a write.
    if (load_data) begin
      state_d     = ARB_BUSY;
      owner_d     = OWNER_DATA;
      mem_req_d   = 1'b1;
      mem_we_d    = d_wr_req;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end else if (load_fetch) begin
      state_d    = ARB_BUSY;
      owner_d    = OWNER_FETCH;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = if_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWNER_FETCH;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

  // Completion is either an ack in BUSY or the forced TERM cycle (rdata 0).
  assign if_valid = (owner_q == OWNER_FETCH) && (done || (state_q == ARB_TERM));
  assign d_valid  = (owner_q == OWNER_DATA)  && (done || (state_q == ARB_TERM));
  assign if_rdata = ((owner_q == OWNER_FETCH) && done) ? mem_rdata : '0;
  assign d_rdata  = ((owner_q == OWNER_DATA) && done && !mem_we_q) ? mem_rdata : '0;

  assign stall_fetch = if_req && !if_valid;
  assign stall_data  = d_req && !d_valid;

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter. A memory model answers
//           each transaction after a chosen number of request cycles; the
//           expected timing of every valid/stall/mem_* output is derived from
//           those latencies arithmetically.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_rd_req, d_wr_req;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          if_valid, d_valid;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_fetch, stall_data, err_timeout, err_proto;

  int tests = 0;
  int fails = 0;

  int            lat_q[$];
  logic [DW-1:0] mem_m[logic [AW-1:0]];
  bit            tmo_seen;
  bit            proto_seen;

  bit busy_m;
  int cnt_m;
  int lat_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .d_rd_req    (d_rd_req),
    .d_wr_req    (d_wr_req),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_valid     (d_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall_fetch (stall_fetch),
    .stall_data  (stall_data),
    .err_timeout (err_timeout),
    .err_proto   (err_proto)
  );

  function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(string tag);
    chk({tag, ".err_timeout"}, 64'(err_timeout), 64'(tmo_seen));
    chk({tag, ".err_proto"},   64'(err_proto),   64'(proto_seen));
  endtask

  // Memory model: acks in the lat-th cycle of a request; acks randomly
  // while no request is outstanding (must be ignored by the arbiter).
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    busy_m    = 1'b0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        busy_m  = 1'b0;
        mem_ack = 1'b0;
      end else begin
        #1;
        if (mem_ack && busy_m) busy_m = 1'b0;
        if (mem_req) begin
          if (!busy_m) begin
            busy_m = 1'b1;
            cnt_m  = 0;
            lat_m  = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
          end
          cnt_m++;
          mem_ack   = (cnt_m == lat_m);
          mem_rdata = mem_ack ? mem_rd(mem_addr) : $urandom;
        end else begin
          busy_m    = 1'b0;
          mem_ack   = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
      end
    end
  end

  // One requester alone; lat > TO means the memory never answers.
  task automatic run_single(bit is_d, bit rd, bit wr, logic [AW-1:0] addr,
                            logic [DW-1:0] wdata, int lat);
    bit            we;
    bit            tmo;
    bit            live;
    int            last;
    logic [DW-1:0] exp_rd;
    we   = is_d && wr;
    tmo  = (lat > TO);
    last = tmo ? TO + 1 : lat;
    @(posedge clk); #1;
    lat_q.push_back(lat);
    if (is_d) begin
      d_rd_req = rd; d_wr_req = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      live = (c >= 1) && !(tmo && (c == last));
      chk("single.stall", 64'(is_d ? stall_data : stall_fetch), 64'(c < last));
      chk("single.valid", 64'(is_d ? d_valid : if_valid), 64'(c == last));
      chk("single.other_valid", 64'(is_d ? if_valid : d_valid), 64'(0));
      chk("single.mem_req", 64'(mem_req), 64'(live));
      if (live) begin
        chk("single.mem_addr", 64'(mem_addr), 64'(addr));
        chk("single.mem_we", 64'(mem_we), 64'(we));
        if (we) chk("single.mem_wdata", 64'(mem_wdata), 64'(wdata));
      end
      if (c == last) begin
        exp_rd = (we || tmo) ? '0 : mem_rd(addr);
        chk("single.rdata", 64'(is_d ? d_rdata : if_rdata), 64'(exp_rd));
        if (we && !tmo) mem_m[addr] = wdata;
      end
    end
    if (tmo) tmo_seen = 1'b1;
    if (is_d && rd && wr) proto_seen = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    @(negedge clk);
    chk("single.idle_mem_req", 64'(mem_req), 64'(0));
    chk_flags("single");
  endtask

  // Fetch and data raised together: data first (l1 cycles), fetch next (l2).
  task automatic run_pair(bit dwe, logic [AW-1:0] daddr, logic [DW-1:0] dwdata,
                          logic [AW-1:0] faddr, int l1, int l2);
    int last;
    last = l1 + l2;
    @(posedge clk); #1;
    lat_q.push_back(l1);
    lat_q.push_back(l2);
    if_req = 1'b1; if_addr = faddr;
    d_rd_req = !dwe; d_wr_req = dwe; d_addr = daddr; d_wdata = dwdata;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      chk("pair.stall_fetch", 64'(stall_fetch), 64'(c < last));
      chk("pair.stall_data", 64'(stall_data), 64'(c < l1));
      chk("pair.d_valid", 64'(d_valid), 64'(c == l1));
      chk("pair.if_valid", 64'(if_valid), 64'(c == last));
      chk("pair.mem_req", 64'(mem_req), 64'(c >= 1));
      if (c >= 1) begin
        chk("pair.mem_addr", 64'(mem_addr), 64'((c <= l1) ? daddr : faddr));
        chk("pair.mem_we", 64'(mem_we), 64'((c <= l1) && dwe));
      end
      if (c == last) chk("pair.if_rdata", 64'(if_rdata), 64'(mem_rd(faddr)));
      if (c == l1) begin
        chk("pair.d_rdata", 64'(d_rdata), 64'(dwe ? '0 : mem_rd(daddr)));
        if (dwe) mem_m[daddr] = dwdata;
        @(posedge clk); #1;
        d_rd_req = 1'b0; d_wr_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("pair.idle_mem_req", 64'(mem_req), 64'(0));
    chk_flags("pair");
  endtask

  initial begin
    int            kind;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] wd;
    int            l1, l2;

    reset = 1'b0;
    if_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tmo_seen = 1'b0; proto_seen = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset.mem_req", 64'(mem_req), 64'(0));
    chk("reset.mem_we", 64'(mem_we), 64'(0));
    chk("reset.mem_addr", 64'(mem_addr), 64'(0));
    chk("reset.mem_wdata", 64'(mem_wdata), 64'(0));
    chk("reset.valids", 64'({if_valid, d_valid}), 64'(0));
    chk("reset.stalls", 64'({stall_fetch, stall_data}), 64'(0));
    chk_flags("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Zero-wait fetch
    mem_m[32'h100] = 32'hE3A0_1005;
    run_single(1'b0, 1'b0, 1'b0, 32'h100, '0, 1);
    // Simultaneous fetch + load, zero-wait
    run_pair(1'b0, 32'h400, '0, 32'h200, 1, 1);
    // Store with three wait cycles
    run_single(1'b1, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4);
    // Store then fetch of the same word
    run_pair(1'b1, 32'h80, 32'hCAFE_F00D, 32'h80, 2, 3);
    // Ack arriving in the very last allowed cycle is not a timeout
    run_single(1'b0, 1'b0, 1'b0, 32'h304, '0, TO);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a1   = AW'($urandom_range(0, 7)) << 2;
      a2   = AW'($urandom_range(0, 7)) << 2;
      wd   = $urandom;
      l1   = $urandom_range(1, 4);
      l2   = $urandom_range(1, 4);
      case (kind)
        0:       run_single(1'b0, 1'b0, 1'b0, a1, '0, l1);
        1:       run_single(1'b1, 1'b1, 1'b0, a1, '0, l1);
        2:       run_single(1'b1, 1'b0, 1'b1, a1, wd, l1);
        default: run_pair(1'($urandom_range(0, 1)), a1, wd, a2, l1, l2);
      endcase
    end

    // No ack: forced completion after TO request cycles
    run_single(1'b1, 1'b1, 1'b0, 32'h300, '0, 1000);
    run_single(1'b0, 1'b0, 1'b0, 32'h100, '0, 2);
    // Read and write together: executed as a write, flagged
    run_single(1'b1, 1'b1, 1'b1, 32'h500, 32'hDEAD_BEEF, 2);
    run_single(1'b1, 1'b1, 1'b0, 32'h500, '0, 1);

    // Asynchronous reset while a transaction is outstanding
    @(posedge clk); #1;
    lat_q.push_back(1000);
    d_wr_req = 1'b1; d_addr = 32'h600; d_wdata = 32'h55AA_55AA;
    repeat (3) @(negedge clk);
    chk("arst.pre_mem_req", 64'(mem_req), 64'(1));
    #2;
    reset = 1'b0; d_wr_req = 1'b0;
    #1;
    tmo_seen = 1'b0; proto_seen = 1'b0;
    chk("arst.mem_req", 64'(mem_req), 64'(0));
    chk("arst.mem_we", 64'(mem_we), 64'(0));
    chk("arst.mem_addr", 64'(mem_addr), 64'(0));
    chk("arst.mem_wdata", 64'(mem_wdata), 64'(0));
    chk_flags("arst");
    @(posedge clk); #1;
    reset = 1'b1;
    run_single(1'b1, 1'b1, 1'b0, 32'h100, '0, TO);
    run_pair(1'b0, 32'h8, '0, 32'hC, 3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
